pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard and stall/flush sequencer for the 5-stage pipeline (F/D/E/M/W).
- Generates operand-forwarding selects for the E stage.
- Detects load-use hazards in D.
- Flushes D/E on a taken branch.
- Runs a small FSM that holds the pipeline while the multi-cycle data memory completes an access in M.
- Drives the stall (enable) and flush (clear) inputs of the inter-stage registers, including the M->W register.

Parameters:
- MEM_LATENCY, 2, data-memory access latency in cycles (>=1); the access occupies M for MEM_LATENCY cycles.
- REG_AW, 4, register-address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- RA1D, RA2D  in  REG_AW  source registers of instruction in D
- RA1E, RA2E  in  REG_AW  source registers of instruction in E
- WA3E  in  REG_AW  destination of instruction in E
- memToRegE  in  1  instruction in E is a load
- WA3M  in  REG_AW  destination of instruction in M
- regWriteM  in  1  instruction in M writes the register file
- memReqM  in  1  instruction in M accesses data memory
- WA3W  in  REG_AW  destination of instruction in W
- regWriteW  in  1  instruction in W writes the register file
- branchTakenE  in  1  branch resolved taken in E
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = W result, 10 = M ALU result
- StallF, StallD, StallE, StallM  out  1  hold the PC or the stage register
- FlushD, FlushE, FlushW  out  1  clear the stage register into a bubble

Behaviour:
Reset and clocking:
- Single clock domain.
- rst is asynchronous and active-high.
- On rst: FSM = RUN, cnt = 0. Stall/flush outputs are then driven only by the combinational terms and are 0 when inputs are idle.
- rst during MEM_WAIT aborts the wait immediately. No flush is issued for the aborted access.

Forwarding (combinational, zero latency):
- ForwardAE = 10 if regWriteM && WA3M==RA1E.
- Else ForwardAE = 01 if regWriteW && WA3W==RA1E.
- Else ForwardAE = 00.
- M has priority over W. ForwardBE is identical using RA2E.
- Forwarding stays valid during stalls.

Load-use (combinational):
- lwStall = memToRegE && (WA3E==RA1D || WA3E==RA2D).
- Effect: StallF = StallD = 1 and FlushE = 1 for that cycle.

Branch:
- branchTakenE gives FlushD = FlushE = 1.
- A taken branch overrides lwStall: StallF/StallD are not asserted, because D is discarded anyway.

Memory FSM, states RUN and MEM_WAIT, with counter cnt of width $clog2(MEM_LATENCY):
- RUN, memReqM=1, MEM_LATENCY>1:
  - memStall = 1 this cycle.
  - Next state MEM_WAIT, cnt <= MEM_LATENCY-2.
- MEM_WAIT, cnt!=0: memStall = 1, cnt decrements.
- MEM_WAIT, cnt==0:
  - memStall = 0; M advances this cycle.
  - memReqM is ignored in this cycle (it belongs to the completing access).
  - Next state RUN.
- MEM_LATENCY==1: the FSM never leaves RUN.
- memStall asserts StallF/D/E/M and FlushW, so W receives a bubble and regWriteW/memToRegW/PCSrcW clear.
- Result: exactly MEM_LATENCY-1 stall cycles per access. Back-to-back accesses each pay the full latency.

Priority while memStall=1:
- lwStall and branch flushes are suppressed: FlushD = FlushE = 0.
- The held E instruction re-raises them after release.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs stallCycles[15:0] and flushEvents[15:0].
  - stallCycles increments on every cycle with StallF=1.
  - flushEvents increments on every cycle with FlushD=1.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and logic are absent.

Decomposition:
Shared package pipe_pkg holds:
- the fwd_sel_e enum (FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10);
- the mem_state_e enum (RUN, MEM_WAIT);
- the REG_AW default.

One natural sub-module, mem_stall_fsm, containing the state register, counter and memStall. Forwarding and load-use logic stay in the top level.

Test Plan:
- Forward priority: regWriteM=1, WA3M=3, regWriteW=1, WA3W=3, RA1E=3 -> ForwardAE=10. Then drop regWriteM -> ForwardAE=01.
- Load-use: memToRegE=1, WA3E=5, RA2D=5 -> one cycle of StallF=StallD=FlushE=1. Next cycle, with memToRegE=0 -> all 0.
- Branch vs load-use: same as the load-use case plus branchTakenE=1 -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait with MEM_LATENCY=3: memReqM pulses high and is held by the stall -> StallM=FlushW=1 for exactly 2 cycles, then 0. Back-to-back second access -> another 2 stall cycles.
- Reset mid-wait, MEM_LATENCY=4: assert rst in the 2nd stall cycle -> stalls drop asynchronously; after rst release with idle inputs, state RUN and all outputs 0.
- With HAZARD_PERF_CNT_EN: 3 load-use events plus 1 access at MEM_LATENCY=3 -> stallCycles=5. 2 branches -> flushEvents=2. Preload to saturation -> counters hold 16'hFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Purpose : shared types and helpers for the pipeline hazard controller.
// Latency : n/a (types, constants and pure functions only).
// Backpr. : n/a.
package pipe_pkg;

  // Default register-address width of the core's register file.
  localparam int REG_AW_DEF = 4;

  // E-stage operand source select.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // Data-memory wait sequencer states.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  // Operand source from the two hit terms; the younger M result wins over W.
  function automatic fwd_sel_e fwd_select(input logic hit_m, input logic hit_w);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (hit_m) begin
      sel = FWD_M;
    end else if (hit_w) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  // Wait-counter width; a latency of 1 never uses the counter but still
  // needs a legal one-bit vector.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_stall_fsm.sv
// Purpose : holds the pipeline while a multi-cycle data-memory access sits in M.
// Latency : mem_stall is combinational from state and mem_req; MEM_LATENCY-1 stall cycles per access.
// Backpr. : mem_stall is the backpressure itself; reset drops it at once and abandons the access.
module mem_stall_fsm
  import pipe_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic mem_stall
);

  localparam int CNT_W = cnt_width(MEM_LATENCY);
  // Cycles still to wait after the first stall cycle spent in RUN.
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (MEM_LATENCY > 1) ? CNT_W'(MEM_LATENCY - 2) : '0;
  localparam logic MULTI_CYCLE = (MEM_LATENCY > 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_raw;

  // State and counter register; reset aborts any wait in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and raw stall; the request seen in the completing
  // cycle belongs to that access and is not a new one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_req && MULTI_CYCLE) begin
          stall_raw = 1'b1;
          state_d   = MEM_WAIT;
          cnt_d     = CNT_LOAD;
        end
      end
      MEM_WAIT: begin
        if (cnt_q != '0) begin
          stall_raw = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // A held request must not re-raise the stall while reset is asserted.
  always_comb begin
    mem_stall = stall_raw & ~rst;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : forwarding selects plus stall/flush sequencing for the 5-stage pipeline.
// Latency : all outputs combinational; memory waits add MEM_LATENCY-1 stall cycles.
// Backpr. : memory stall holds F/D/E/M and bubbles W; load-use holds F/D and bubbles E.
// Optional: define HAZARD_PERF_CNT_EN to add the stallCycles/flushEvents counters.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int REG_AW      = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic              memToRegE,
  input  logic [REG_AW-1:0] WA3M,
  input  logic              regWriteM,
  input  logic              memReqM,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              regWriteW,
  input  logic              branchTakenE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]       stallCycles,
  output logic [15:0]       flushEvents
`endif
);

  logic mem_stall;
  logic lw_stall;

  mem_stall_fsm #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_mem_stall_fsm (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (memReqM),
    .mem_stall (mem_stall)
  );

  // E-stage operand forwarding; independent of stalls so held operands stay correct.
  always_comb begin
    ForwardAE = fwd_select(regWriteM && (WA3M == RA1E), regWriteW && (WA3W == RA1E));
    ForwardBE = fwd_select(regWriteM && (WA3M == RA2E), regWriteW && (WA3W == RA2E));
  end

  // Load in E whose destination is a source of the instruction in D.
  always_comb begin
    lw_stall = memToRegE && ((WA3E == RA1D) || (WA3E == RA2D));
  end

  // Stall/flush combination: a memory wait freezes everything and masks the
  // E-stage hazards (they re-raise after release); a taken branch discards D,
  // so holding D for a load-use would be pointless.
  always_comb begin
    StallF = mem_stall | (lw_stall & ~branchTakenE);
    StallD = mem_stall | (lw_stall & ~branchTakenE);
    StallE = mem_stall;
    StallM = mem_stall;
    FlushD = ~mem_stall & branchTakenE;
    FlushE = ~mem_stall & (branchTakenE | lw_stall);
    FlushW = mem_stall;
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters for stall cycles and branch flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCycles <= '0;
      flushEvents <= '0;
    end else begin
      if (StallF && (stallCycles != 16'hFFFF)) begin
        stallCycles <= stallCycles + 16'd1;
      end
      if (FlushD && (flushEvents != 16'hFFFF)) begin
        flushEvents <= flushEvents + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose : directed self-checking bench for pipeline_hazard_ctrl at latencies 3, 4 and 1.
// Latency : inputs driven on the falling edge, outputs sampled 1 ns later.
// Backpr. : memory requests are held high while stalled, as the pipeline would.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       memToRegE, regWriteM, memReqM, regWriteW, branchTakenE;

  // Per-instance outputs: suffix 3/4/1 is the MEM_LATENCY of that instance.
  logic [1:0] fa3, fb3, fa4, fb4, fa1, fb1;
  logic       sf3, sd3, se3, sm3, fd3, fe3, fw3;
  logic       sf4, sd4, se4, sm4, fd4, fe4, fw4;
  logic       sf1, sd1, se1, sm1, fd1, fe1, fw1;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] sc3, fev3, sc4, fev4, sc1, fev1;
`endif

  // Control vectors, bit order {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
  logic [6:0] ctl3, ctl4, ctl1;
  assign ctl3 = {sf3, sd3, se3, sm3, fd3, fe3, fw3};
  assign ctl4 = {sf4, sd4, se4, sm4, fd4, fe4, fw4};
  assign ctl1 = {sf1, sd1, se1, sm1, fd1, fe1, fw1};

  localparam logic [6:0] C_IDLE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_MEM  = 7'b1111001;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_LATENCY(3), .REG_AW(4)) dut3 (
    .clk(clk), .rst(rst), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .memToRegE(memToRegE), .WA3M(WA3M), .regWriteM(regWriteM),
    .memReqM(memReqM), .WA3W(WA3W), .regWriteW(regWriteW), .branchTakenE(branchTakenE),
    .ForwardAE(fa3), .ForwardBE(fb3), .StallF(sf3), .StallD(sd3), .StallE(se3),
    .StallM(sm3), .FlushD(fd3), .FlushE(fe3), .FlushW(fw3)
`ifdef HAZARD_PERF_CNT_EN
    , .stallCycles(sc3), .flushEvents(fev3)
`endif
  );

  pipeline_hazard_ctrl #(.MEM_LATENCY(4), .REG_AW(4)) dut4 (
    .clk(clk), .rst(rst), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .memToRegE(memToRegE), .WA3M(WA3M), .regWriteM(regWriteM),
    .memReqM(memReqM), .WA3W(WA3W), .regWriteW(regWriteW), .branchTakenE(branchTakenE),
    .ForwardAE(fa4), .ForwardBE(fb4), .StallF(sf4), .StallD(sd4), .StallE(se4),
    .StallM(sm4), .FlushD(fd4), .FlushE(fe4), .FlushW(fw4)
`ifdef HAZARD_PERF_CNT_EN
    , .stallCycles(sc4), .flushEvents(fev4)
`endif
  );

  pipeline_hazard_ctrl #(.MEM_LATENCY(1), .REG_AW(4)) dut1 (
    .clk(clk), .rst(rst), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .memToRegE(memToRegE), .WA3M(WA3M), .regWriteM(regWriteM),
    .memReqM(memReqM), .WA3W(WA3W), .regWriteW(regWriteW), .branchTakenE(branchTakenE),
    .ForwardAE(fa1), .ForwardBE(fb1), .StallF(sf1), .StallD(sd1), .StallE(se1),
    .StallM(sm1), .FlushD(fd1), .FlushE(fe1), .FlushW(fw1)
`ifdef HAZARD_PERF_CNT_EN
    , .stallCycles(sc1), .flushEvents(fev1)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    memToRegE = 1'b0; regWriteM = 1'b0; memReqM = 1'b0;
    regWriteW = 1'b0; branchTakenE = 1'b0;
  endtask

  // Load in E writing r5, instruction in D reads r5 on port B.
  task automatic drive_load_use();
    memToRegE = 1'b1; WA3E = 4'd5; RA1D = 4'd0; RA2D = 4'd5;
  endtask

  logic mem_pat3 [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic mem_pat4 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    drive_idle();
    rst = 1'b1;
    #1;
    check_val("reset_ctl3", 32'(ctl3), 32'(C_IDLE));
    check_val("reset_ctl4", 32'(ctl4), 32'(C_IDLE));
    check_val("reset_fwd3", 32'({fa3, fb3}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Forwarding priority: M over W, then W alone, then per-port independence.
    @(negedge clk);
    RA1E = 4'd3; RA2E = 4'd7; WA3M = 4'd3; regWriteM = 1'b1; WA3W = 4'd3; regWriteW = 1'b1;
    #1;
    check_val("fwdA_M_prio", 32'(fa3), 32'b10);
    check_val("fwdB_nohit", 32'(fb3), 32'b00);
    regWriteM = 1'b0;
    #1;
    check_val("fwdA_W", 32'(fa3), 32'b01);
    regWriteM = 1'b1; WA3M = 4'd4; RA2E = 4'd4;
    #1;
    check_val("fwdA_W_Mmiss", 32'(fa3), 32'b01);
    check_val("fwdB_M", 32'(fb3), 32'b10);
    regWriteW = 1'b0; regWriteM = 1'b0;
    #1;
    check_val("fwd_rf", 32'({fa3, fb3}), 32'd0);

    // Load-use on port B, then cleared, then on port A, then no overlap.
    @(negedge clk);
    drive_idle();
    drive_load_use();
    #1;
    check_val("lu_portB", 32'(ctl3), 32'(C_LU));
    @(negedge clk);
    memToRegE = 1'b0;
    #1;
    check_val("lu_cleared", 32'(ctl3), 32'(C_IDLE));
    @(negedge clk);
    memToRegE = 1'b1; RA1D = 4'd5; RA2D = 4'd1;
    #1;
    check_val("lu_portA", 32'(ctl3), 32'(C_LU));
    WA3E = 4'd6;
    #1;
    check_val("lu_nomatch", 32'(ctl3), 32'(C_IDLE));

    // Taken branch overrides load-use.
    @(negedge clk);
    drive_idle();
    drive_load_use();
    branchTakenE = 1'b1;
    #1;
    check_val("br_over_lu", 32'(ctl3), 32'(C_BR));
    memToRegE = 1'b0;
    #1;
    check_val("br_alone", 32'(ctl3), 32'(C_BR));

    // Memory access at latency 3: first cycle also carries load-use, branch and
    // a forwarding hit, which the stall must mask (forwarding stays live).
    @(negedge clk);
    drive_idle();
    drive_load_use();
    branchTakenE = 1'b1; memReqM = 1'b1;
    RA1E = 4'd2; WA3M = 4'd2; regWriteM = 1'b1;
    #1;
    check_val("mem_prio_ctl3", 32'(ctl3), 32'(C_MEM));
    check_val("mem_fwd_live", 32'(fa3), 32'b10);
    check_val("lat1_no_stall", 32'(ctl1), 32'(C_BR));
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      drive_idle();
      memReqM = 1'b1;
      #1;
      check_val($sformatf("mem3_cyc%0d", i), 32'(ctl3), mem_pat3[i] ? 32'(C_MEM) : 32'(C_IDLE));
      check_val($sformatf("lat1_cyc%0d", i), 32'(ctl1), 32'(C_IDLE));
    end
    @(negedge clk);
    memReqM = 1'b0;
    #1;
    check_val("mem3_after", 32'(ctl3), 32'(C_IDLE));
    repeat (4) @(negedge clk);

    // Reset in the second stall cycle at latency 4, request still held.
    memReqM = 1'b1;
    #1;
    check_val("mem4_cyc0", 32'(ctl4), 32'(C_MEM));
    @(negedge clk);
    #1;
    check_val("mem4_cyc1", 32'(ctl4), 32'(C_MEM));
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_async_drop", 32'(ctl4), 32'(C_IDLE));
    @(negedge clk);
    #1;
    check_val("rst_held", 32'(ctl4), 32'(C_IDLE));
    rst = 1'b0;
    memReqM = 1'b0;
    #1;
    check_val("rst_release_idle", 32'(ctl4), 32'(C_IDLE));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      memReqM = 1'b1;
      #1;
      check_val($sformatf("mem4_fresh%0d", i), 32'(ctl4), mem_pat4[i] ? 32'(C_MEM) : 32'(C_IDLE));
    end
    @(negedge clk);
    memReqM = 1'b0;

`ifdef HAZARD_PERF_CNT_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("perf_rst_sc", 32'(sc3), 32'd0);
    repeat (3) begin
      @(negedge clk);
      drive_idle();
      drive_load_use();
      @(negedge clk);
      drive_idle();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      memReqM = 1'b1;
    end
    repeat (2) begin
      @(negedge clk);
      drive_idle();
      branchTakenE = 1'b1;
      @(negedge clk);
      drive_idle();
    end
    @(negedge clk);
    check_val("perf_stall5", 32'(sc3), 32'd5);
    check_val("perf_flush2", 32'(fev3), 32'd2);
    drive_load_use();
    repeat (65540) @(negedge clk);
    drive_idle();
    @(negedge clk);
    check_val("perf_sat", 32'(sc3), 32'hFFFF);
    check_val("perf_flush_hold", 32'(fev3), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
